// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: tick-gated load-to-limit sequencer (one-shot/auto-reload, pause, clear); out o_count/o_tc/o_busy/o_done/o_state
module N_bit_counter #(
  parameter int N = 4
) (
  input  logic [N-1:0] r1,
  input  logic         up,
  output logic [N-1:0] result
);
  assign result = up ? r1 + N'(1) : r1 - N'(1);
endmodule

module counter_seq_ctrl #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clear,
  input  logic         i_start,
  input  logic         i_pause,
  input  logic         i_tick,
  input  logic         i_up,
  input  logic         i_mode,
  input  logic [N-1:0] i_load_val,
  input  logic [N-1:0] i_limit,
  output logic [N-1:0] o_count,
  output logic         o_tc,
  output logic         o_busy,
  output logic         o_done,
  output logic [1:0]   o_state
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  state_t state, state_d;
  logic [N-1:0] count, count_d, load_q, load_d, limit_q, limit_d, step;
  logic tc_d, up_q, up_d, mode_q, mode_d;
  N_bit_counter #(.N(N)) u_step (.r1(count), .up(up_q), .result(step));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      count   <= '0;
      o_tc    <= 1'b0;
      up_q    <= 1'b0;
      mode_q  <= 1'b0;
      load_q  <= '0;
      limit_q <= '0;
    end else begin
      state   <= state_d;
      count   <= count_d;
      o_tc    <= tc_d;
      up_q    <= up_d;
      mode_q  <= mode_d;
      load_q  <= load_d;
      limit_q <= limit_d;
    end
  always_comb begin
    state_d = state;
    count_d = count;
    tc_d    = 1'b0;
    up_d    = up_q;
    mode_d  = mode_q;
    load_d  = load_q;
    limit_d = limit_q;
    if (i_clear) begin
      state_d = IDLE;
      count_d = '0;
    end else if (i_start && (state == IDLE || state == DONE)) begin
      up_d    = i_up;
      mode_d  = i_mode;
      load_d  = i_load_val;
      limit_d = i_limit;
      count_d = i_load_val;
      state_d = RUN;
    end else if (state == RUN) begin
      if (i_pause) state_d = PAUSE;
      else if (i_tick) begin
        tc_d    = count == limit_q;
        count_d = !tc_d ? step : mode_q ? load_q : count;
        state_d = tc_d && !mode_q ? DONE : RUN;
      end
    end else if (state == PAUSE && !i_pause) state_d = RUN;
  end
  assign o_count = count;
  assign o_busy  = state == RUN || state == PAUSE;
  assign o_done  = state == DONE;
  assign o_state = state;
endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb_counter_seq_ctrl: table-driven directed vectors plus async-reset sequence for counter_seq_ctrl
module tb_counter_seq_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic i_clear = 0, i_start = 0, i_pause = 0, i_tick = 0, i_up = 0, i_mode = 0;
  logic [3:0] i_load_val = 0, i_limit = 0, o_count;
  logic o_tc, o_busy, o_done;
  logic [1:0] o_state;
  int n_vec = 0, n_err = 0;
  typedef struct {
    logic clr, st, pa, tk, up, md;
    logic [3:0] ld, lim, ec;
    logic etc;
    logic [1:0] es;
  } vec_t;
  vec_t v[$];
  always #5 clk = ~clk;
  counter_seq_ctrl #(.N(4)) dut (
    .clk(clk), .rst_n(rst_n), .i_clear(i_clear), .i_start(i_start), .i_pause(i_pause),
    .i_tick(i_tick), .i_up(i_up), .i_mode(i_mode), .i_load_val(i_load_val), .i_limit(i_limit),
    .o_count(o_count), .o_tc(o_tc), .o_busy(o_busy), .o_done(o_done), .o_state(o_state)
  );
  function automatic vec_t mk(input logic clr, st, pa, tk, up, md, input logic [3:0] ld, lim, ec,
                              input logic etc, input logic [1:0] es);
    vec_t x;
    x.clr = clr; x.st = st; x.pa = pa; x.tk = tk; x.up = up; x.md = md;
    x.ld = ld; x.lim = lim; x.ec = ec; x.etc = etc; x.es = es;
    return x;
  endfunction
  task automatic chk(input string nm, input logic [3:0] ec, input logic etc, input logic [1:0] es);
    logic eb, ed;
    eb = es == 2'd1 || es == 2'd2;
    ed = es == 2'd3;
    n_vec++;
    if (o_count !== ec || o_tc !== etc || o_state !== es || o_busy !== eb || o_done !== ed) begin
      n_err++;
      $display("FAIL %s: got count=%0d tc=%b state=%0d busy=%b done=%b, want count=%0d tc=%b state=%0d busy=%b done=%b",
               nm, o_count, o_tc, o_state, o_busy, o_done, ec, etc, es, eb, ed);
    end
  endtask
  initial begin
    // clr st pa tk up md ld lim | count tc state
    // one-shot up 0..3
    v.push_back(mk(0,1,0,0,1,0, 0,3, 0,0,1));
    v.push_back(mk(0,0,0,1,0,0, 0,0, 1,0,1));
    v.push_back(mk(0,0,0,0,0,0, 0,0, 1,0,1));
    v.push_back(mk(0,0,0,1,0,0, 0,0, 2,0,1));
    v.push_back(mk(0,0,0,1,0,0, 0,0, 3,0,1));
    v.push_back(mk(0,0,0,1,0,0, 0,0, 3,1,3));
    v.push_back(mk(0,0,0,1,0,0, 0,0, 3,0,3));
    // reload down 5->2
    v.push_back(mk(0,1,0,0,0,1, 5,2, 5,0,1));
    v.push_back(mk(0,0,0,1,0,0, 0,0, 4,0,1));
    v.push_back(mk(0,0,0,1,0,0, 0,0, 3,0,1));
    v.push_back(mk(0,0,0,1,0,0, 0,0, 2,0,1));
    v.push_back(mk(0,0,0,1,0,0, 0,0, 5,1,1));
    v.push_back(mk(0,0,0,1,0,0, 0,0, 4,0,1));
    // start in RUN ignored, including new load/limit
    v.push_back(mk(0,1,0,0,1,0, 9,9, 4,0,1));
    v.push_back(mk(0,0,0,1,1,0, 9,9, 3,0,1));
    v.push_back(mk(0,0,0,1,0,0, 0,0, 2,0,1));
    v.push_back(mk(0,0,0,1,0,0, 0,0, 5,1,1));
    v.push_back(mk(1,0,0,0,0,0, 0,0, 0,0,0));
    // wrap up 14->1
    v.push_back(mk(0,1,0,0,1,0, 14,1, 14,0,1));
    v.push_back(mk(0,0,0,1,0,0, 0,0, 15,0,1));
    v.push_back(mk(0,0,0,1,0,0, 0,0, 0,0,1));
    v.push_back(mk(0,0,0,1,0,0, 0,0, 1,0,1));
    v.push_back(mk(0,0,0,1,0,0, 0,0, 1,1,3));
    // wrap down 1->14, restarted from DONE
    v.push_back(mk(0,1,0,0,0,0, 1,14, 1,0,1));
    v.push_back(mk(0,0,0,1,0,0, 0,0, 0,0,1));
    v.push_back(mk(0,0,0,1,0,0, 0,0, 15,0,1));
    v.push_back(mk(0,0,0,1,0,0, 0,0, 14,0,1));
    v.push_back(mk(0,0,0,1,0,0, 0,0, 14,1,3));
    v.push_back(mk(1,0,0,0,0,0, 0,0, 0,0,0));
    // pause at 2
    v.push_back(mk(0,1,0,0,1,0, 0,5, 0,0,1));
    v.push_back(mk(0,0,0,1,0,0, 0,0, 1,0,1));
    v.push_back(mk(0,0,0,1,0,0, 0,0, 2,0,1));
    v.push_back(mk(0,0,1,1,0,0, 0,0, 2,0,2));
    v.push_back(mk(0,0,1,1,0,0, 0,0, 2,0,2));
    v.push_back(mk(0,0,1,1,0,0, 0,0, 2,0,2));
    v.push_back(mk(0,0,0,1,0,0, 0,0, 2,0,1));
    v.push_back(mk(0,0,0,1,0,0, 0,0, 3,0,1));
    v.push_back(mk(1,0,0,1,0,0, 0,0, 0,0,0));
    // load == limit one-shot
    v.push_back(mk(0,1,0,0,1,0, 9,9, 9,0,1));
    v.push_back(mk(0,0,0,1,0,0, 0,0, 9,1,3));
    v.push_back(mk(0,0,0,0,0,0, 0,0, 9,0,3));
    // clear wins over start in DONE
    v.push_back(mk(1,1,0,0,1,0, 7,7, 0,0,0));
    // terminal pulse in reload mode right before async reset
    v.push_back(mk(0,1,0,0,1,1, 0,0, 0,0,1));
    v.push_back(mk(0,0,0,1,0,0, 0,0, 0,1,1));
    #12;
    chk("reset_state", 0, 0, 0);
    @(negedge clk) rst_n = 1'b1;
    foreach (v[k]) begin
      @(negedge clk);
      i_clear = v[k].clr; i_start = v[k].st; i_pause = v[k].pa; i_tick = v[k].tk;
      i_up = v[k].up; i_mode = v[k].md; i_load_val = v[k].ld; i_limit = v[k].lim;
      @(posedge clk);
      #1 chk($sformatf("vec%0d", k), v[k].ec, v[k].etc, v[k].es);
    end
    #1 rst_n = 1'b0;
    #1 chk("async_reset_midrun", 0, 0, 0);
    @(posedge clk);
    #1 chk("reset_held", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1; i_tick = 1'b0;
    i_start = 1'b1; i_up = 1'b0; i_mode = 1'b0; i_load_val = 4'd0; i_limit = 4'd15;
    @(posedge clk);
    #1 chk("post_reset_start", 0, 0, 1);
    @(negedge clk) begin i_start = 1'b0; i_tick = 1'b1; end
    @(posedge clk);
    #1 chk("post_reset_down_wrap", 15, 0, 1);
    @(negedge clk);
    @(posedge clk);
    #1 chk("post_reset_tc", 15, 1, 3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
